// File: rtl/uart_tx_port.sv
// 8N1 serial transmitter driven by the E100 command/response toggle handshake.
// One byte per accepted toggle; response echoes the accepted command once the stop bit completes.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       command,
  input  logic [7:0] data,
  output logic       response,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  logic              cmd_q;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;

  // Frame sequencer: every output and counter is a register of this one block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      response <= 1'b0;
      busy     <= 1'b0;
      cmd_q    <= 1'b0;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (command != response) begin
            cmd_q <= command;
            busy  <= 1'b1;
            state <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end

        // One spare cycle so data and command synchronizers agree before capture.
        SETTLE: begin
          shift    <= data;
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= DONE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DONE: begin
          response <= cmd_q;
          busy     <= 1'b0;
          baud_cnt <= '0;
          state    <= IDLE;
        end

        default: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
